// File: rtl/jk_count_sequencer_pkg.sv
// Shared encodings for the JK count sequencer: command opcodes and FSM states.
package jk_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_CLEAR = 2'b01,
        OP_UP    = 2'b10,
        OP_DOWN  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Counting commands take cmd_n steps; LOAD/CLEAR always take one cycle.
    function automatic logic is_count(input op_e op);
        return (op == OP_UP) || (op == OP_DOWN);
    endfunction

endpackage

// File: rtl/jk_count_sequencer_if.sv
// Command channel between a host and the JK count sequencer (valid/ready).
interface jk_count_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int NW    = WIDTH
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [NW-1:0]    cmd_n;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output cmd_n,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  cmd_n,
        output cmd_ready
    );
endinterface

// File: rtl/jk_count_sequencer_step_decode.sv
// Combinational j/k generator: turns the active command and current bank value
// into per-cell j/k drives, and reports the terminal (all-ones/all-zero) state.
module jk_step_decode
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  op_e              op,
    input  logic             exec,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             all_ones,
    output logic             all_zero
);
    // up_pre_s[i] = AND(q[i-1:0]); dn_pre_s[i] = AND(~q[i-1:0]); index 0 is 1.
    logic [WIDTH:0] up_pre_s;
    logic [WIDTH:0] dn_pre_s;

    assign up_pre_s[0] = 1'b1;
    assign dn_pre_s[0] = 1'b1;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_prefix
        assign up_pre_s[gi+1] = up_pre_s[gi] & q[gi];
        assign dn_pre_s[gi+1] = dn_pre_s[gi] & ~q[gi];
    end

    // The full-width prefix is the wrap condition for the current step.
    assign all_ones = up_pre_s[WIDTH];
    assign all_zero = dn_pre_s[WIDTH];

    // Select j/k per command; every cell holds when not executing.
    always_comb begin
        j = {WIDTH{1'b0}};
        k = {WIDTH{1'b0}};
        if (exec) begin
            case (op)
                OP_LOAD: begin
                    j = data;
                    k = ~data;
                end
                OP_CLEAR: begin
                    j = {WIDTH{1'b0}};
                    k = {WIDTH{1'b1}};
                end
                OP_UP: begin
                    j = up_pre_s[WIDTH-1:0];
                    k = up_pre_s[WIDTH-1:0];
                end
                OP_DOWN: begin
                    j = dn_pre_s[WIDTH-1:0];
                    k = dn_pre_s[WIDTH-1:0];
                end
                default: begin
                    j = {WIDTH{1'b0}};
                    k = {WIDTH{1'b0}};
                end
            endcase
        end else begin
            j = {WIDTH{1'b0}};
            k = {WIDTH{1'b0}};
        end
    end
endmodule

// File: rtl/jkff.sv
// Single JK flip-flop storage cell with asynchronous active-low clear.
module jkff (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);
    logic q_r;

    // JK update: 00 hold, 01 reset, 10 set, 11 toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q_r <= 1'b0;
                2'b10:   q_r <= 1'b1;
                2'b11:   q_r <= ~q_r;
                default: q_r <= q_r;
            endcase
        end
    end

    assign q = q_r;
endmodule

// File: rtl/jk_count_sequencer.sv
// Command-driven controller for a bank of JK cells: LOAD, CLEAR, COUNT_UP N,
// COUNT_DOWN N, with done and wrap status pulses.
module jk_count_sequencer
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NW    = WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    jk_count_sequencer_if.slave  cmd,
    output logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 done,
    output logic                 wrap
);
    localparam logic [NW-1:0] REM_ZERO = {NW{1'b0}};
    localparam logic [NW-1:0] REM_ONE  = {{(NW-1){1'b0}}, 1'b1};

    state_e           state_r;
    op_e              op_r;
    logic [WIDTH-1:0] data_r;
    logic [NW-1:0]    rem_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic             wrap_r;

    op_e              op_in_s;
    logic             exec_s;
    logic [WIDTH-1:0] j_s;
    logic [WIDTH-1:0] k_s;
    logic [WIDTH-1:0] q_s;
    logic             all_ones_s;
    logic             all_zero_s;
    logic             wrap_step_s;

    assign op_in_s = op_e'(cmd.cmd_op);
    assign exec_s  = (state_r == ST_EXEC);

    // The step about to be applied wraps if it leaves all-ones (up) or zero (down).
    assign wrap_step_s = exec_s &&
                         (((op_r == OP_UP)   && all_ones_s) ||
                          ((op_r == OP_DOWN) && all_zero_s));

    jk_step_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .op       (op_r),
        .exec     (exec_s),
        .q        (q_s),
        .data     (data_r),
        .j        (j_s),
        .k        (k_s),
        .all_ones (all_ones_s),
        .all_zero (all_zero_s)
    );

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jkff u_cell (
            .clk   (clk),
            .rst_n (reset),
            .j     (j_s[gi]),
            .k     (k_s[gi]),
            .q     (q_s[gi])
        );
    end

    // Sequencer FSM: accept, execute steps, one DONE cycle; status is registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            op_r    <= OP_LOAD;
            data_r  <= {WIDTH{1'b0}};
            rem_r   <= REM_ZERO;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            wrap_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        op_r    <= op_in_s;
                        data_r  <= cmd.cmd_data;
                        rem_r   <= cmd.cmd_n;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        if (is_count(op_in_s) && (cmd.cmd_n == REM_ZERO)) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_EXEC;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    wrap_r <= wrap_step_s;
                    if (!is_count(op_r) || (rem_r == REM_ONE)) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        rem_r <= rem_r - REM_ONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = ready_r;
    assign q             = q_s;
    assign busy          = busy_r;
    assign done          = done_r;
    assign wrap          = wrap_r;
endmodule

// File: tb/tb_jk_count_sequencer.sv
// Self-checking bench for jk_count_sequencer (WIDTH=4): directed scenarios plus
// randomized back-to-back commands checked against an arithmetic model.
module tb_jk_count_sequencer;
    import jk_seq_pkg::*;

    localparam int WIDTH = 4;
    localparam int NW    = 4;
    localparam int MODV  = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             wrap;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_q      = 0;

    jk_count_sequencer_if #(.WIDTH(WIDTH), .NW(NW)) cmd_if ();

    jk_count_sequencer #(.WIDTH(WIDTH), .NW(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .cmd   (cmd_if),
        .q     (q),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int wrapm(input int x);
        return ((x % MODV) + MODV) % MODV;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op,
                         input logic [3:0] d, input logic [3:0] n);
        cmd_if.cmd_valid = v;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = d;
        cmd_if.cmd_n     = n;
    endtask

    // Issue a command from a ready cycle and wait (bounded) for ready again.
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] d, input logic [3:0] n);
        drive(1'b1, op, d, n);
        step();
        drive(1'b0, 2'b00, 4'h0, 4'h0);
        for (int i = 0; i < 40 && cmd_if.cmd_ready !== 1'b1; i++) step();
        tests_run++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL do_cmd_timeout: ready=%b required 1", cmd_if.cmd_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, OP_LOAD, 4'hF, 4'h0);
        repeat (3) step();
        tests_run++;
        if ({q, done, wrap, busy} !== {4'h0, 3'b000}) begin
            tests_failed++;
            $display("FAIL reset_state: q=%h done=%b wrap=%b busy=%b required 0/0/0/0", q, done, wrap, busy);
        end
        reset = 1'b1;
        drive(1'b1, OP_LOAD, 4'h9, 4'h0);
        tests_run++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: ready=%b required 1", cmd_if.cmd_ready);
        end
        step();
        drive(1'b0, OP_LOAD, 4'h0, 4'h0);
        tests_run++;
        if ({busy, cmd_if.cmd_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_first_accept: busy/ready=%b%b required 10", busy, cmd_if.cmd_ready);
        end
        step();
        tests_run++;
        if ({q, done} !== {4'h9, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_first_done: q=%h done=%b required 9/1", q, done);
        end
        step();
        model_q = 9;
    endtask

    task automatic test_load_handshake();
        drive(1'b1, OP_LOAD, 4'hA, 4'h0);
        step();
        drive(1'b1, OP_LOAD, 4'h5, 4'h0);
        tests_run++;
        if (cmd_if.cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_ready_low: ready=%b required 0", cmd_if.cmd_ready);
        end
        step();
        tests_run++;
        if ({q, done} !== {4'hA, 1'b1}) begin
            tests_failed++;
            $display("FAIL load_done: q=%h done=%b required a/1", q, done);
        end
        step();
        drive(1'b0, OP_LOAD, 4'h0, 4'h0);
        tests_run++;
        if ({cmd_if.cmd_ready, done, q} !== {2'b10, 4'hA}) begin
            tests_failed++;
            $display("FAIL load_ready_back: ready=%b done=%b q=%h required 1/0/a", cmd_if.cmd_ready, done, q);
        end
        step();
        tests_run++;
        if ({q, busy} !== {4'hA, 1'b0}) begin
            tests_failed++;
            $display("FAIL load_ignored_second: q=%h busy=%b required a/0", q, busy);
        end
        model_q = 10;
    endtask

    task automatic test_count_up_wrap();
        logic [5:0] exp_s [4];
        exp_s[0] = {4'hE, 2'b00};
        exp_s[1] = {4'hF, 2'b00};
        exp_s[2] = {4'h0, 2'b10};
        exp_s[3] = {4'h1, 2'b01};
        do_cmd(OP_LOAD, 4'hE, 4'h0);
        drive(1'b1, OP_UP, 4'h0, 4'h3);
        step();
        drive(1'b0, OP_LOAD, 4'h0, 4'h0);
        for (int c = 0; c < 4; c++) begin
            tests_run++;
            if ({q, wrap, done} !== exp_s[c]) begin
                tests_failed++;
                $display("FAIL count_up_T%0d: q/wrap/done=%h/%b/%b required %h/%b/%b",
                         c + 1, q, wrap, done, exp_s[c][5:2], exp_s[c][1], exp_s[c][0]);
            end
            step();
        end
        model_q = 1;
    endtask

    task automatic test_count_down_wrap();
        logic [5:0] exp_s [3];
        exp_s[0] = {4'h0, 2'b00};
        exp_s[1] = {4'hF, 2'b10};
        exp_s[2] = {4'hE, 2'b01};
        do_cmd(OP_CLEAR, 4'h0, 4'h0);
        drive(1'b1, OP_DOWN, 4'h0, 4'h2);
        step();
        drive(1'b0, OP_LOAD, 4'h0, 4'h0);
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if ({q, wrap, done} !== exp_s[c]) begin
                tests_failed++;
                $display("FAIL count_down_T%0d: q/wrap/done=%h/%b/%b required %h/%b/%b",
                         c + 1, q, wrap, done, exp_s[c][5:2], exp_s[c][1], exp_s[c][0]);
            end
            step();
        end
        model_q = 14;
    endtask

    task automatic test_zero_steps();
        do_cmd(OP_LOAD, 4'h7, 4'h0);
        drive(1'b1, OP_UP, 4'h0, 4'h0);
        step();
        drive(1'b0, OP_LOAD, 4'h0, 4'h0);
        tests_run++;
        if ({q, wrap, done, busy} !== {4'h7, 3'b011}) begin
            tests_failed++;
            $display("FAIL zero_steps_done: q=%h wrap=%b done=%b busy=%b required 7/0/1/1", q, wrap, done, busy);
        end
        step();
        tests_run++;
        if ({q, cmd_if.cmd_ready, done} !== {4'h7, 2'b10}) begin
            tests_failed++;
            $display("FAIL zero_steps_ready: q=%h ready=%b done=%b required 7/1/0", q, cmd_if.cmd_ready, done);
        end
        model_q = 7;
    endtask

    task automatic test_clear_and_abort();
        do_cmd(OP_LOAD, 4'hC, 4'h0);
        drive(1'b1, OP_CLEAR, 4'h0, 4'h0);
        step();
        drive(1'b0, OP_LOAD, 4'h0, 4'h0);
        tests_run++;
        if (q !== 4'hC) begin
            tests_failed++;
            $display("FAIL clear_T1: q=%h required c", q);
        end
        step();
        tests_run++;
        if ({q, done} !== {4'h0, 1'b1}) begin
            tests_failed++;
            $display("FAIL clear_done: q=%h done=%b required 0/1", q, done);
        end
        step();
        drive(1'b1, OP_UP, 4'h0, 4'hA);
        step();
        drive(1'b0, OP_LOAD, 4'h0, 4'h0);
        repeat (4) step();
        tests_run++;
        if ({q, done} !== {4'h4, 1'b0}) begin
            tests_failed++;
            $display("FAIL abort_before: q=%h done=%b required 4/0", q, done);
        end
        #1 reset = 1'b0;
        #1;
        tests_run++;
        if ({q, done, wrap, busy} !== {4'h0, 3'b000}) begin
            tests_failed++;
            $display("FAIL abort_reset: q=%h done=%b wrap=%b busy=%b required 0/0/0/0", q, done, wrap, busy);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        drive(1'b1, OP_LOAD, 4'h3, 4'h0);
        tests_run++;
        if ({cmd_if.cmd_ready, done} !== 2'b10) begin
            tests_failed++;
            $display("FAIL abort_ready: ready=%b done=%b required 1/0", cmd_if.cmd_ready, done);
        end
        step();
        drive(1'b0, OP_LOAD, 4'h0, 4'h0);
        step();
        tests_run++;
        if ({q, done} !== {4'h3, 1'b1}) begin
            tests_failed++;
            $display("FAIL abort_reload: q=%h done=%b required 3/1", q, done);
        end
        step();
        model_q = 3;
    endtask

    task automatic test_random_back_to_back();
        int op, d, n, nsteps, dir, v, eq;
        logic ew, ed;
        logic cnt;
        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 3));
            d  = int'($urandom_range(0, 15));
            n  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) begin
                drive(1'b0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                step();
            end
            drive(1'b1, 2'(op), 4'(d), 4'(n));
            tests_run++;
            if ({cmd_if.cmd_ready, q} !== {1'b1, 4'(model_q)}) begin
                tests_failed++;
                $display("FAIL rand_idle it%0d: ready=%b q=%h required 1/%h", it, cmd_if.cmd_ready, q, model_q);
            end
            step();
            cnt    = (op >= 2);
            nsteps = cnt ? n : 1;
            dir    = (op == 3) ? -1 : 1;
            for (int c = 1; c <= nsteps + 1; c++) begin
                drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                if (cnt) begin
                    eq = wrapm(model_q + dir * (c - 1));
                    v  = wrapm(model_q + dir * (c - 2));
                    ew = (c >= 2) && ((dir == 1) ? (v == MODV - 1) : (v == 0));
                end else begin
                    eq = (c == 1) ? model_q : ((op == 0) ? d : 0);
                    ew = 1'b0;
                end
                ed = (c == nsteps + 1);
                tests_run++;
                if ({q, wrap, done, busy, cmd_if.cmd_ready} !== {4'(eq), ew, ed, 2'b10}) begin
                    tests_failed++;
                    $display("FAIL rand_cmd it%0d op%0d n%0d c%0d: q=%h wrap=%b done=%b busy=%b ready=%b required %h/%b/%b/1/0",
                             it, op, n, c, q, wrap, done, busy, cmd_if.cmd_ready, eq, ew, ed);
                end
                step();
            end
            model_q = cnt ? wrapm(model_q + dir * n) : ((op == 0) ? d : 0);
        end
        drive(1'b0, OP_LOAD, 4'h0, 4'h0);
        tests_run++;
        if ({cmd_if.cmd_ready, busy, q} !== {2'b10, 4'(model_q)}) begin
            tests_failed++;
            $display("FAIL rand_final: ready=%b busy=%b q=%h required 1/0/%h", cmd_if.cmd_ready, busy, q, model_q);
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, OP_LOAD, 4'h0, 4'h0);
        test_reset();
        test_load_handshake();
        test_count_up_wrap();
        test_count_down_wrap();
        test_zero_steps();
        test_clear_and_abort();
        test_random_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/jk_count_sequencer.md
Name: jk_count_sequencer

Overview:
Command-driven controller for a bank of WIDTH JK flip-flop cells. It accepts one command at a time over a valid/ready handshake and drives per-bit j/k so the bank executes that command. Commands are load, clear, count up N steps or count down N steps. The block sits between a host/control FSM and the storage bank, and provides completion and wrap status.

Parameters:
WIDTH, 4, number of JK cells in the bank (count/load width); legal range 2..16
NW, WIDTH, width of step-count field cmd_n

Ports:
clk  in  1  single clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command this cycle
cmd_op  in  2  00 LOAD, 01 CLEAR, 10 COUNT_UP, 11 COUNT_DOWN
cmd_data  in  WIDTH  load value (LOAD only; ignored otherwise)
cmd_n  in  NW  number of count steps (COUNT_* only)
q  out  WIDTH  current bank contents (outputs of the JK cells)
busy  out  1  high in EXEC and DONE
done  out  1  one-cycle pulse: command complete, q holds final value
wrap  out  1  one-cycle pulse, cycle after any step that wrapped

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, q=0, done=0, wrap=0, busy=0, internal op/data/remaining registers cleared. After release, cmd_ready=1.
- States: IDLE, EXEC, DONE. cmd_ready = (state==IDLE). busy = !IDLE.
- Accept when cmd_valid & cmd_ready in cycle T. Op, data and cmd_n are latched at the end of T. Inputs are ignored whenever cmd_ready=0.
- IDLE -> EXEC on accept. Exception: a COUNT_* command with cmd_n=0 goes IDLE -> DONE, with no step and q unchanged.
- LOAD/CLEAR: one EXEC cycle (T+1), then DONE.
  - LOAD drives j=data, k=~data.
  - CLEAR drives j=0, k=1.
- COUNT_*: remaining counter is loaded with cmd_n. Each EXEC cycle applies one step and decrements remaining. The cycle with remaining==1 is the last EXEC cycle; the next state is DONE.
- Outside EXEC, j=k=0 on all bits (hold).
- Count-up step: j_i=k_i=AND(q[i-1:0]). Count-down step: j_i=k_i=AND(~q[i-1:0]). Bit 0 toggles on every step. Arithmetic is modulo 2^WIDTH.
- Latency: q holds the final value from cycle T+N+1, where N=1 for LOAD/CLEAR and N=cmd_n for counts (N=0 gives T+1).
- done=1 for exactly the DONE cycle. DONE -> IDLE unconditionally, so cmd_ready rises at T+N+2. Back-to-back commands therefore have one DONE gap.
- wrap: registered pulse, asserted in the cycle after a step takes q from all-ones to 0 (up) or from 0 to all-ones (down). One pulse per wrap event; multiple wraps in one command give multiple pulses. Never asserted for LOAD/CLEAR.
- Reset mid-command: immediate abort. q=0, no done pulse, no wrap pulse. A new command is accepted on the first cycle after release.
- cmd_valid may drop without acceptance. No ordering or queuing: at most one command is in flight.

Decomposition:
- Package jk_seq_pkg holds:
  - op encodings: OP_LOAD, OP_CLEAR, OP_UP, OP_DOWN;
  - state encoding: ST_IDLE, ST_EXEC, ST_DONE.
- Storage is WIDTH instances of the team's existing jkff cell, in a generate loop. The cells share clk and are cleared by the block's active-low reset.
- One combinational sub-module, jk_step_decode, maps (op, exec, q, data) to j/k vectors. Keep the FSM, remaining counter and wrap detect in the top module.

Test Plan:
1. Hold reset low 3 cycles with cmd_valid=1 -> q=0, done=0, wrap=0, busy=0. After release, cmd_ready=1 and the first command is accepted on the next edge.
2. LOAD 4'hA accepted at T -> q=4'hA and done=1 at T+2, cmd_ready=1 at T+3. cmd_valid held high with LOAD 4'h5 during T+1..T+2 is not accepted.
3. From q=4'hE, COUNT_UP cmd_n=3 -> q=F,0,1 over T+2..T+4. wrap=1 at T+3 only, done=1 at T+4, final q=4'h1.
4. From q=4'h0, COUNT_DOWN cmd_n=2 -> q=F then E. wrap=1 at T+2 only, done at T+3.
5. COUNT_UP cmd_n=0 from q=4'h7 -> done=1 at T+1, q stays 4'h7, wrap=0.
6. CLEAR from q=4'hC -> q=0 at T+2. Then COUNT_UP cmd_n=10, with reset pulsed low after 4 steps -> q=0 immediately, no done. A following LOAD 4'h3 completes normally.
